// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline issue arbiter: opcodes, instruction
// field positions, FSM states and the write-back tracker entry.
package pipe_pkg;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

   localparam int OP_MSB  = 7;
   localparam int OP_LSB  = 6;
   localparam int RS1_MSB = 5;
   localparam int RS1_LSB = 4;
   localparam int RS2_MSB = 3;
   localparam int RS2_LSB = 2;
   localparam int RD_MSB  = 1;
   localparam int RD_LSB  = 0;

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_e;

   typedef struct packed {
      logic       v;
      logic       src;
      logic [1:0] rd;
   } trk_entry_t;

   function automatic logic is_writer(input logic [7:0] inst);
      return inst[OP_MSB:OP_LSB] != OP_NOP;
   endfunction

   // Saturating up/down count; simultaneous inc and dec cancel out.
   function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic inc,
                                             input logic dec);
      logic [1:0] res;
      if (inc && !dec) begin
         if (cnt != 2'd3) res = cnt + 2'd1;
         else             res = cnt;
      end else if (dec && !inc) begin
         if (cnt != 2'd0) res = cnt - 2'd1;
         else             res = cnt;
      end else begin
         res = cnt;
      end
      return res;
   endfunction

endpackage

// File: rtl/pipe_wb_tracker.sv
// Shift register following each issued instruction until its register write
// is visible; the last stage is the retire notification.
module pipe_wb_tracker
   import pipe_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       push_src,
   input  logic [1:0] push_rd,
   output logic       retire_valid,
   output logic       retire_src,
   output logic [1:0] retire_rd,
   output logic       empty
);

   trk_entry_t [DEPTH-1:0] stage_q;
   trk_entry_t [DEPTH-1:0] stage_d;

   always_comb begin
      stage_d = stage_q;
      if (push) begin
         stage_d[0] = '{v: 1'b1, src: push_src, rd: push_rd};
      end else begin
         stage_d[0] = '{v: 1'b0, src: 1'b0, rd: 2'b00};
      end
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
      empty = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         empty = empty & ~stage_q[i].v;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q <= {($bits(stage_q)){1'b0}};
      end else begin
         stage_q <= stage_d;
      end
   end

   assign retire_valid = stage_q[DEPTH-1].v;
   assign retire_src   = stage_q[DEPTH-1].src;
   assign retire_rd    = stage_q[DEPTH-1].rd;

endmodule

// File: rtl/pipe_issue_arbiter.sv
// Round-robin issue arbiter for two requesters sharing the add/sub/and
// pipeline, with write-back tracking and a drain fence.
module pipe_issue_arbiter
   import pipe_pkg::*;
#(
   parameter int INST_W = 8,
   parameter int WB_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [INST_W-1:0] req0_inst,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [INST_W-1:0] req1_inst,
   output logic              req1_ready,
   input  logic              fence_req,
   output logic              fence_done,
   output logic [INST_W-1:0] inst_out,
   output logic              retire_valid,
   output logic              retire_src,
   output logic [1:0]        retire_rd,
   output logic              busy
);

   state_e            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [1:0]        cnt0_q, cnt0_d;
   logic [1:0]        cnt1_q, cnt1_d;
   logic              gnt0_s, gnt1_s;
   logic              grant_src_s;
   logic              push_s;
   logic              trk_empty_s;
   logic [INST_W-1:0] grant_inst_s;

   // A fence request wins over pending requests in the same cycle.
   always_comb begin
      state_d    = state_q;
      gnt0_s     = 1'b0;
      gnt1_s     = 1'b0;
      fence_done = 1'b0;
      case (state_q)
         ISSUE: begin
            if (fence_req) begin
               state_d = DRAIN;
            end else begin
               gnt0_s = req0_valid && (!req1_valid || last_grant_q);
               gnt1_s = req1_valid && (!req0_valid || !last_grant_q);
            end
         end
         DRAIN: begin
            if (trk_empty_s) state_d = DONE;
            else             state_d = DRAIN;
         end
         DONE: begin
            fence_done = 1'b1;
            state_d    = ISSUE;
         end
         default: state_d = ISSUE;
      endcase
   end

   always_comb begin
      grant_src_s = gnt1_s;
      if (gnt0_s)      grant_inst_s = req0_inst;
      else if (gnt1_s) grant_inst_s = req1_inst;
      else             grant_inst_s = {INST_W{1'b0}};
      push_s = (gnt0_s || gnt1_s) && is_writer(grant_inst_s);
      if (gnt0_s)      last_grant_d = 1'b0;
      else if (gnt1_s) last_grant_d = 1'b1;
      else             last_grant_d = last_grant_q;
      cnt0_d     = cnt_update(cnt0_q, push_s && !grant_src_s, retire_valid && !retire_src);
      cnt1_d     = cnt_update(cnt1_q, push_s && grant_src_s, retire_valid && retire_src);
      req0_ready = gnt0_s;
      req1_ready = gnt1_s;
      inst_out   = grant_inst_s;
      busy       = !trk_empty_s || (state_q != ISSUE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ISSUE;
         last_grant_q <= 1'b1;
         cnt0_q       <= 2'd0;
         cnt1_q       <= 2'd0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
      end
   end

   pipe_wb_tracker #(
      .DEPTH (WB_LAT)
   ) u_tracker (
      .clk          (clk),
      .rst          (rst),
      .push         (push_s),
      .push_src     (grant_src_s),
      .push_rd      (grant_inst_s[RD_MSB:RD_LSB]),
      .retire_valid (retire_valid),
      .retire_src   (retire_src),
      .retire_rd    (retire_rd),
      .empty        (trk_empty_s)
   );

endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// Directed scenarios plus randomized traffic against an event-queue model of
// issue, retire timing and fence completion.
module tb_pipe_issue_arbiter;
   import pipe_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0;
   logic [7:0] req0_inst = 8'h00;
   logic       req0_ready;
   logic       req1_valid = 1'b0;
   logic [7:0] req1_inst = 8'h00;
   logic       req1_ready;
   logic       fence_req = 1'b0;
   logic       fence_done;
   logic [7:0] inst_out;
   logic       retire_valid;
   logic       retire_src;
   logic [1:0] retire_rd;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipe_issue_arbiter #(.INST_W(8), .WB_LAT(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .req0_valid   (req0_valid),
      .req0_inst    (req0_inst),
      .req0_ready   (req0_ready),
      .req1_valid   (req1_valid),
      .req1_inst    (req1_inst),
      .req1_ready   (req1_ready),
      .fence_req    (fence_req),
      .fence_done   (fence_done),
      .inst_out     (inst_out),
      .retire_valid (retire_valid),
      .retire_src   (retire_src),
      .retire_rd    (retire_rd),
      .busy         (busy)
   );

   // Retire src/rd only carry meaning while retire_valid is high.
   function automatic logic [15:0] obs_vec();
      return {req0_ready, req1_ready, inst_out, retire_valid, retire_valid & retire_src,
              retire_valid ? retire_rd : 2'b00, fence_done, busy};
   endfunction

   function automatic logic [15:0] mk(input logic r0, input logic r1, input logic [7:0] inst,
                                      input logic rv, input logic rs, input logic [1:0] rd,
                                      input logic fd, input logic bsy);
      return {r0, r1, inst, rv, rs, rd, fd, bsy};
   endfunction

   task automatic drive(input logic v0, input logic [7:0] i0, input logic v1,
                        input logic [7:0] i1, input logic fr, input logic r);
      @(posedge clk);
      #1;
      req0_valid = v0;
      req0_inst  = i0;
      req1_valid = v1;
      req1_inst  = i1;
      fence_req  = fr;
      rst        = r;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst        = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      fence_req  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] e;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
         e = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
         n_tests++;
         if (obs_vec() !== e) begin
            n_fail++;
            $display("FAIL reset_idle c=%0d got %h expected %h", c, obs_vec(), e);
         end
      end
   endtask

   task automatic test_single();
      logic [15:0] e;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         drive(c == 5, 8'h46, 1'b0, 8'h00, 1'b0, 1'b0);
         e = mk(c == 5, 1'b0, (c == 5) ? 8'h46 : 8'h00, c == 8, 1'b0,
                (c == 8) ? 2'd2 : 2'd0, 1'b0, (c >= 6) && (c <= 8));
         n_tests++;
         if (obs_vec() !== e) begin
            n_fail++;
            $display("FAIL single c=%0d got %h expected %h", c, obs_vec(), e);
         end
         if (c == 7 || c == 9) begin
            n_tests++;
            if (dut.cnt0_q !== ((c == 7) ? 2'd1 : 2'd0)) begin
               n_fail++;
               $display("FAIL single_cnt0 c=%0d got %0d expected %0d", c, dut.cnt0_q,
                        (c == 7) ? 1 : 0);
            end
         end
      end
   endtask

   task automatic test_alternate();
      logic [15:0] e;
      logic        r0, r1;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         drive(k < 4, 8'h45, k < 4, 8'h0c, 1'b0, 1'b0);
         r0 = (k < 4) && (k % 2 == 0);
         r1 = (k < 4) && (k % 2 == 1);
         e = mk(r0, r1, r0 ? 8'h45 : (r1 ? 8'h0c : 8'h00), (k == 3) || (k == 5), 1'b0,
                ((k == 3) || (k == 5)) ? 2'd1 : 2'd0, 1'b0, (k >= 1) && (k <= 5));
         n_tests++;
         if (obs_vec() !== e) begin
            n_fail++;
            $display("FAIL alternate k=%0d got %h expected %h", k, obs_vec(), e);
         end
      end
   endtask

   task automatic test_fence_drain();
      logic [15:0] e;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         drive(k == 0, 8'h87, (k >= 1) && (k <= 6), 8'h59, (k == 1) || (k == 3), 1'b0);
         e = mk(k == 0, k == 6, (k == 0) ? 8'h87 : ((k == 6) ? 8'h59 : 8'h00), k == 3, 1'b0,
                (k == 3) ? 2'd3 : 2'd0, k == 5, ((k >= 1) && (k <= 5)) || (k >= 7));
         n_tests++;
         if (obs_vec() !== e) begin
            n_fail++;
            $display("FAIL fence_drain k=%0d got %h expected %h", k, obs_vec(), e);
         end
      end
   endtask

   task automatic test_fence_coincident();
      logic [15:0] e;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(k <= 3, 8'hc1, 1'b1, 8'h0e, k == 0, 1'b0);
         e = mk(k == 3, k == 4, (k == 3) ? 8'hc1 : ((k == 4) ? 8'h0e : 8'h00), 1'b0, 1'b0,
                2'b00, k == 2, (k == 1) || (k == 2) || (k == 4));
         n_tests++;
         if (obs_vec() !== e) begin
            n_fail++;
            $display("FAIL fence_coincident k=%0d got %h expected %h", k, obs_vec(), e);
         end
      end
   endtask

   task automatic test_reset_midop();
      logic [15:0] e;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         drive((k == 0) || (k == 5), (k == 0) ? 8'h46 : 8'h42,
               (k == 1) || (k == 5) || (k == 6), (k == 1) ? 8'h4b : 8'h43, 1'b0, k == 2);
         e = mk((k == 0) || (k == 5), (k == 1) || (k == 6),
                (k == 0) ? 8'h46 : (k == 1) ? 8'h4b : (k == 5) ? 8'h42 : (k == 6) ? 8'h43 : 8'h00,
                1'b0, 1'b0, 2'b00, 1'b0, (k == 1) || (k == 2) || (k >= 6));
         n_tests++;
         if (obs_vec() !== e) begin
            n_fail++;
            $display("FAIL reset_midop k=%0d got %h expected %h", k, obs_vec(), e);
         end
         if (k == 3) begin
            n_tests++;
            if ({dut.cnt0_q, dut.cnt1_q} !== 4'h0) begin
               n_fail++;
               $display("FAIL reset_midop_cnt got %h expected 0", {dut.cnt0_q, dut.cnt1_q});
            end
         end
      end
   endtask

   typedef struct {
      int         r;
      logic       src;
      logic [1:0] rd;
   } ev_t;

   task automatic test_random();
      ev_t         q[$];
      int          last_r = -100;
      int          f_c = 0;
      int          done_c = 0;
      int          c0, c1;
      logic        fence_on = 1'b0;
      logic        last_g = 1'b1;
      logic        v0 = 1'b0, v1 = 1'b0;
      logic [7:0]  i0 = 8'h00, i1 = 8'h00, iss;
      logic        fr, g0, g1, draining, exp_fd, rv, rs;
      logic [1:0]  rd;
      logic [19:0] got, e;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (!v0 && $urandom_range(0, 2) == 0) begin v0 = 1'b1; i0 = 8'($urandom); end
         if (!v1 && $urandom_range(0, 2) == 0) begin v1 = 1'b1; i1 = 8'($urandom); end
         fr = ($urandom_range(0, 29) == 0);
         drive(v0, i0, v1, i1, fr, 1'b0);
         while (q.size() > 0 && q[0].r < c) void'(q.pop_front());
         if (fence_on && c > done_c) fence_on = 1'b0;
         draining = fence_on && (c > f_c);
         exp_fd   = fence_on && (c == done_c);
         g0 = 1'b0;
         g1 = 1'b0;
         if (!draining) begin
            if (fr) begin
               fence_on = 1'b1;
               f_c      = c;
               done_c   = (last_r + 2 > c + 2) ? last_r + 2 : c + 2;
            end else if (v0 && v1) begin
               g0 = last_g;
               g1 = !last_g;
            end else begin
               g0 = v0;
               g1 = v1;
            end
         end
         if (g0 || g1) last_g = g1;
         iss = g0 ? i0 : (g1 ? i1 : 8'h00);
         rv = 1'b0; rs = 1'b0; rd = 2'b00;
         if (q.size() > 0 && q[0].r == c) begin rv = 1'b1; rs = q[0].src; rd = q[0].rd; end
         c0 = 0; c1 = 0;
         foreach (q[j]) begin
            if (q[j].src) c1++;
            else          c0++;
         end
         e   = {mk(g0, g1, iss, rv, rs, rd, exp_fd, draining || (q.size() > 0)), 2'(c0), 2'(c1)};
         got = {obs_vec(), dut.cnt0_q, dut.cnt1_q};
         n_tests++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL random c=%0d got %h expected %h", c, got, e);
         end
         if ((g0 || g1) && iss[7:6] != OP_NOP) begin
            q.push_back('{r: c + 3, src: g1, rd: iss[1:0]});
            last_r = c + 3;
         end
         if (g0) v0 = 1'b0;
         if (g1) v1 = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_fence_drain();
      test_fence_coincident();
      test_reset_midop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
